instr_loader: RTL

- Upstream program loader for the instruction SRAM. Runs before the core fetches anything.
- Accepts a byte stream through a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory through the SRAM init port (init_addr/init_data), then checks a trailing checksum.
- On a checksum match it raises core_enable, which drives the PC register and SRAM ChipEnable; on a mismatch it holds the core off.

---
 rtl/instr_loader_if.sv | 21 ++
 rtl/instr_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream in and SRAM init port out of the instruction loader
interface instr_loader_if #(
    parameter int ADDR_W = 5
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [31:0]       init_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, init_we, init_addr, init_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, init_we, init_addr, init_data
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - loads count-prefixed, checksummed byte stream into instruction SRAM
module instr_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_loader_if.slave     bus,
    output logic              core_enable,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic              ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic [ADDR_W-1:0] count_last;
    logic [1:0]        lane;
    logic [23:0]       word_buf;
    logic [7:0]        sum;
    logic [7:0]        sum_nx;
    logic [7:0]        count_m1;
    logic              accept;
    logic              last_word;

    assign bus.in_ready  = ready_q;
    assign bus.init_we   = we_q;
    assign bus.init_addr = addr_q;
    assign bus.init_data = data_q;

    assign accept    = bus.in_valid && ready_q;
    assign sum_nx    = sum + bus.in_data;
    assign last_word = (lane == 2'd3) && (word_idx == last_idx);
    assign count_m1  = bus.in_data - 8'd1;

    // A zero count means a full memory; oversized counts are clamped so writes never wrap.
    always_comb begin
        count_last = count_m1[ADDR_W-1:0];
        if (bus.in_data == 8'd0 || 32'(bus.in_data) > DEPTH)
            count_last = ADDR_W'(DEPTH - 1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start)  state_nx = S_COUNT;
            S_COUNT: if (accept) state_nx = S_DATA;
            S_DATA:  if (accept && last_word) state_nx = S_CHECK;
            S_CHECK: if (accept) state_nx = (sum_nx == 8'd0) ? S_DONE : S_ERROR;
            S_DONE:  if (start)  state_nx = S_COUNT;
            S_ERROR: if (start)  state_nx = S_COUNT;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            ready_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            word_idx     <= '0;
            last_idx     <= '0;
            lane         <= '0;
            word_buf     <= '0;
            sum          <= '0;
            core_enable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == S_COUNT) || (state_nx == S_DATA) || (state_nx == S_CHECK);
            we_q    <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_enable  <= 1'b0;
                        words_loaded <= '0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        last_idx <= count_last;
                        word_idx <= '0;
                        lane     <= '0;
                        sum      <= '0;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        sum  <= sum_nx;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            we_q         <= 1'b1;
                            addr_q       <= word_idx;
                            data_q       <= {bus.in_data, word_buf};
                            words_loaded <= words_loaded + 1'b1;
                            word_idx     <= word_idx + 1'b1;
                        end else begin
                            word_buf[8*lane +: 8] <= bus.in_data;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (sum_nx == 8'd0) begin
                            done        <= 1'b1;
                            core_enable <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
